// File: rtl/digit_buf_pkg.sv
// Shared opcode definitions for the keypad digit buffer blocks.
package digit_buf_pkg;

    localparam int unsigned OP_W = 2;

    // Operation applied on each push-button rising edge
    typedef enum logic [OP_W-1:0] {
        OP_SHIFT_IN  = 2'b00,
        OP_BACKSPACE = 2'b01,
        OP_CLEAR     = 2'b10,
        OP_ROTATE    = 2'b11
    } op_e;

endpackage : digit_buf_pkg

// File: rtl/digit_shift_buffer_if.sv
// Bus between the debounced keypad inputs, the digit buffer and the display.
//   master: drives push_i/op_i/digit_i, observes buffer state
//   slave : the digit buffer itself
interface digit_shift_buffer_if
    import digit_buf_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                      push_i;
    op_e                       op_i;
    logic [DIGIT_W-1:0]        digit_i;
    logic [DEPTH*DIGIT_W-1:0]  data_o;
    logic [CNT_W-1:0]          count_o;
    logic                      full_o;
    logic                      empty_o;
    logic                      overflow_o;

    modport master (
        output push_i, op_i, digit_i,
        input  data_o, count_o, full_o, empty_o, overflow_o
    );

    modport slave (
        input  push_i, op_i, digit_i,
        output data_o, count_o, full_o, empty_o, overflow_o
    );

endinterface : digit_shift_buffer_if

// File: rtl/digit_shift_buffer_push_edge.sv
// Rising-edge detector for a debounced push-button level.
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : button level
//   fire_o     : one-cycle pulse on the rising edge (combinational from push_i)
module push_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    output logic fire_o
);

    logic push_q;

    // Reset to 1 so a button held through reset release does not fire
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            push_q <= 1'b1;
        end else begin
            push_q <= push_i;
        end
    end

    assign fire_o = push_i & ~push_q;

endmodule : push_edge

// File: rtl/digit_shift_buffer.sv
// Keypad digit shift buffer: one shift-in/backspace/clear/rotate per button
// press, with valid-digit count and overflow pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of digit_shift_buffer_if
//                (push_i, op_i, digit_i in; data_o, count_o, full_o,
//                 empty_o, overflow_o out). Slot 0 is data_o[DIGIT_W-1:0].
module digit_shift_buffer
    import digit_buf_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    digit_shift_buffer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                             fire;
    logic [DEPTH-1:0][DIGIT_W-1:0]    slots_q, slots_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic                             overflow_q, overflow_d;
    logic                             full, empty;

    push_edge u_push_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (bus.push_i),
        .fire_o (fire)
    );

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));

    // Next-state for buffer, count and overflow pulse
    always_comb begin
        slots_d    = slots_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        if (fire) begin
            case (bus.op_i)
                OP_SHIFT_IN: begin
                    slots_d = {slots_q[DEPTH-2:0], bus.digit_i};
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                OP_BACKSPACE: begin
                    // Empty buffer: nothing to remove, state untouched
                    if (!empty) begin
                        slots_d = {DIGIT_W'(0), slots_q[DEPTH-1:1]};
                        count_d = count_q - CNT_W'(1);
                    end
                end
                OP_CLEAR: begin
                    slots_d = '0;
                    count_d = '0;
                end
                OP_ROTATE: begin
                    slots_d = {slots_q[DEPTH-2:0], slots_q[DEPTH-1]};
                end
            endcase
        end
    end

    // State registers; reset overrides any push in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slots_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            slots_q    <= slots_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.data_o     = slots_q;
    assign bus.count_o    = count_q;
    assign bus.overflow_o = overflow_q;
    assign bus.full_o     = full;
    assign bus.empty_o    = empty;

endmodule : digit_shift_buffer
